fc_dense_layer: RTL and testbench

- Fully-connected output stage directly downstream of the convolution/max-pool/flatten engine.
- After the flatten memory (L2, csel 3'b101) is complete, streams its N_IN 4.16 fixed-point entries against a per-neuron weight ROM and produces N_OUT signed 4.16 logits.
- Writes the logits to output memory L3 (csel_wr 3'b110).
- One multiply-accumulate per cycle, one neuron at a time.

---
 rtl/fc_dense_layer.sv | 204 ++++++++++++++++++++
 tb/tb_fc_dense_layer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_dense_layer.sv
// Fully-connected output stage: one MAC per cycle over the flatten memory,
// one neuron at a time, with rounded and saturated 4.16 logits written to L3.
module fc_dense_layer #(
    parameter int N_IN  = 2048,
    parameter int N_OUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        crd,
    output logic [11:0] caddr_rd,
    output logic [2:0]  csel_rd,
    input  logic [19:0] cdata_rd,
    output logic [13:0] waddr,
    input  logic [19:0] wdata,
    output logic [1:0]  bias_sel,
    input  logic [19:0] bias_data,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic [19:0] cdata_wr,
    output logic [2:0]  csel_wr
);

    localparam logic [11:0] LAST_IDX    = 12'(N_IN - 1);
    localparam logic [1:0]  LAST_NEURON = 2'(N_OUT - 1);
    localparam logic [2:0]  SEL_FLAT    = 3'b101;
    localparam logic [2:0]  SEL_OUT     = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [11:0]         r_idx;
    logic [11:0]         w_idx_nxt;
    logic [1:0]          r_neuron;
    logic [1:0]          w_neuron_nxt;

    logic signed [39:0]  r_prod;
    logic                r_prod_vld;
    logic signed [51:0]  r_acc;

    logic signed [39:0]  w_cdata_sx;
    logic signed [39:0]  w_wdata_sx;
    logic signed [39:0]  w_prod;
    logic signed [51:0]  w_acc_sum;
    logic signed [51:0]  w_bias_ext;
    logic signed [51:0]  w_sum;
    logic [19:0]         w_result;

    // Round-to-4.16 already applied in sum; clamp when bits above 3.16 disagree.
    function automatic logic [19:0] saturate(input logic [51:0] sum);
        logic [19:0] res;
        if (sum[51:35] != {17{sum[51]}}) begin
            res = sum[51] ? 20'h80000 : 20'h7FFFF;
        end else begin
            res = sum[35:16];
        end
        return res;
    endfunction

    assign w_cdata_sx = {{20{cdata_rd[19]}}, cdata_rd};
    assign w_wdata_sx = {{20{wdata[19]}}, wdata};
    assign w_prod     = w_cdata_sx * w_wdata_sx;
    assign w_acc_sum  = r_acc + (r_prod_vld ? {{12{r_prod[39]}}, r_prod} : 52'sd0);
    assign w_bias_ext = {{16{bias_data[19]}}, bias_data, 16'h0000};
    assign w_sum      = w_acc_sum + w_bias_ext + 52'sd32768;
    assign w_result   = saturate(w_sum);

    // State, index and neuron registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= 12'd0;
            r_neuron <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_neuron <= w_neuron_nxt;
        end
    end

    // Next-state, index and neuron sequencing.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_neuron_nxt = r_neuron;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_MAC;
                    w_idx_nxt    = 12'd0;
                    w_neuron_nxt = 2'd0;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_MAC: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_idx_nxt   = r_idx + 12'd1;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (r_neuron == LAST_NEURON) begin
                    w_state_nxt  = S_DONE;
                end else begin
                    w_state_nxt  = S_MAC;
                    w_idx_nxt    = 12'd0;
                    w_neuron_nxt = r_neuron + 2'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_idx_nxt    = 12'd0;
                w_neuron_nxt = 2'd0;
            end
        endcase
    end

    // Multiply-accumulate datapath; cleared after each write so neurons never mix.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod     <= 40'sd0;
            r_prod_vld <= 1'b0;
            r_acc      <= 52'sd0;
        end else begin
            case (r_state)
                S_MAC: begin
                    r_prod     <= w_prod;
                    r_prod_vld <= 1'b1;
                    r_acc      <= w_acc_sum;
                end
                S_DRAIN: begin
                    r_prod     <= 40'sd0;
                    r_prod_vld <= 1'b0;
                    r_acc      <= w_acc_sum;
                end
                default: begin
                    r_prod     <= 40'sd0;
                    r_prod_vld <= 1'b0;
                    r_acc      <= 52'sd0;
                end
            endcase
        end
    end

    // Output registers, loaded from the state being entered so ports match it.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            caddr_rd <= 12'd0;
            csel_rd  <= 3'b000;
            waddr    <= 14'd0;
            bias_sel <= 2'd0;
            cwr      <= 1'b0;
            caddr_wr <= 12'd0;
            cdata_wr <= 20'd0;
            csel_wr  <= 3'b000;
        end else begin
            busy     <= (w_state_nxt == S_MAC) || (w_state_nxt == S_DRAIN) ||
                        (w_state_nxt == S_WRITE);
            done     <= (w_state_nxt == S_DONE);
            crd      <= (w_state_nxt == S_MAC);
            csel_rd  <= (w_state_nxt == S_MAC) ? SEL_FLAT : 3'b000;
            bias_sel <= w_neuron_nxt;
            if (w_state_nxt == S_MAC) begin
                caddr_rd <= w_idx_nxt;
                waddr    <= {w_neuron_nxt, w_idx_nxt};
            end else begin
                caddr_rd <= caddr_rd;
                waddr    <= waddr;
            end
            if (w_state_nxt == S_WRITE) begin
                cwr      <= 1'b1;
                caddr_wr <= {10'd0, r_neuron};
                cdata_wr <= w_result;
                csel_wr  <= SEL_OUT;
            end else begin
                cwr      <= 1'b0;
                caddr_wr <= 12'd0;
                cdata_wr <= 20'd0;
                csel_wr  <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_fc_dense_layer.sv
// Directed bench for fc_dense_layer: a default-size instance and a 1x1 instance.
module tb_fc_dense_layer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endfunction

    // Instance A: default parameters
    logic        rst_a, start_a, busy_a, done_a, crd_a, cwr_a;
    logic [11:0] caddr_rd_a, caddr_wr_a;
    logic [2:0]  csel_rd_a, csel_wr_a;
    logic [19:0] cdata_rd_a, wdata_a, bias_a, cdata_wr_a;
    logic [13:0] waddr_a;
    logic [1:0]  bias_sel_a;
    logic [19:0] cur_data, cur_bias;
    logic [3:0][19:0] cur_w;

    assign cdata_rd_a = cur_data;
    assign wdata_a    = cur_w[waddr_a[13:12]];
    assign bias_a     = cur_bias;

    fc_dense_layer dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .crd(crd_a), .caddr_rd(caddr_rd_a), .csel_rd(csel_rd_a), .cdata_rd(cdata_rd_a),
        .waddr(waddr_a), .wdata(wdata_a), .bias_sel(bias_sel_a), .bias_data(bias_a),
        .cwr(cwr_a), .caddr_wr(caddr_wr_a), .cdata_wr(cdata_wr_a), .csel_wr(csel_wr_a)
    );

    // Instance B: N_IN=1, N_OUT=1
    logic        rst_b, start_b, busy_b, done_b, crd_b, cwr_b;
    logic [11:0] caddr_rd_b, caddr_wr_b;
    logic [2:0]  csel_rd_b, csel_wr_b;
    logic [19:0] data_b, w_b, bias_b, cdata_wr_b;
    logic [13:0] waddr_b;
    logic [1:0]  bias_sel_b;

    fc_dense_layer #(.N_IN(1), .N_OUT(1)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .crd(crd_b), .caddr_rd(caddr_rd_b), .csel_rd(csel_rd_b), .cdata_rd(data_b),
        .waddr(waddr_b), .wdata(w_b), .bias_sel(bias_sel_b), .bias_data(bias_b),
        .cwr(cwr_b), .caddr_wr(caddr_wr_b), .cdata_wr(cdata_wr_b), .csel_wr(csel_wr_b)
    );

    logic [11:0] wa_addr[$], wb_addr[$];
    logic [19:0] wa_data[$], wb_data[$];

    // Write capture and memory-select checks on every cycle.
    always @(negedge clk) begin
        if (cwr_a) begin
            wa_addr.push_back(caddr_wr_a);
            wa_data.push_back(cdata_wr_a);
        end
        if (cwr_b) begin
            wb_addr.push_back(caddr_wr_b);
            wb_data.push_back(cdata_wr_b);
        end
        chk("csel_rd_a", 72'(csel_rd_a), crd_a ? 72'h5 : 72'h0);
        chk("csel_wr_a", 72'(csel_wr_a), cwr_a ? 72'h6 : 72'h0);
        chk("csel_rd_b", 72'(csel_rd_b), crd_b ? 72'h5 : 72'h0);
        chk("csel_wr_b", 72'(csel_wr_b), cwr_b ? 72'h6 : 72'h0);
    end

    typedef struct {
        string            name;
        logic [19:0]      data;
        logic [3:0][19:0] w;
        logic [19:0]      bias;
        logic [3:0][19:0] exp;
    } vec_t;

    vec_t va[5];
    vec_t vb[2];

    task automatic run_a(input string nm, input logic [3:0][19:0] exp, input bit pulse_busy);
        int n;
        wa_addr.delete();
        wa_data.delete();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n = 1;
        while (done_a !== 1'b1 && n < 9000) begin
            @(negedge clk);
            n++;
            start_a = pulse_busy && (n == 100);
        end
        start_a = 1'b0;
        chk({nm, " cycles"}, 72'(n), 72'd8201);
        chk({nm, " busy_at_done"}, 72'(busy_a), 72'd0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk({nm, " done_pulse"}, 72'(done_a), 72'd0);
        chk({nm, " start_in_done"}, 72'(busy_a), 72'd0);
        chk({nm, " nwrites"}, 72'(wa_addr.size()), 72'd4);
        for (int i = 0; i < 4 && i < wa_addr.size(); i++) begin
            chk($sformatf("%s addr%0d", nm, i), 72'(wa_addr[i]), 72'(i));
            chk($sformatf("%s data%0d", nm, i), 72'(wa_data[i]), 72'(exp[i]));
        end
    endtask

    task automatic run_b(input string nm, input logic [19:0] exp);
        int n;
        wb_addr.delete();
        wb_data.delete();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        n = 1;
        while (done_b !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " cycles"}, 72'(n), 72'd4);
        @(negedge clk);
        chk({nm, " nwrites"}, 72'(wb_addr.size()), 72'd1);
        if (wb_addr.size() > 0) begin
            chk({nm, " addr"}, 72'(wb_addr[0]), 72'd0);
            chk({nm, " data"}, 72'(wb_data[0]), 72'(exp));
        end
    endtask

    initial begin
        int n;
        va[0].name = "ones";    va[0].data = 20'h10000; va[0].w = {4{20'h00010}};
        va[0].bias = 20'h00000; va[0].exp  = {4{20'h08000}};
        va[1].name = "negbias"; va[1].data = 20'h10000; va[1].w = {4{20'h00010}};
        va[1].bias = 20'hF0000; va[1].exp  = {4{20'hF8000}};
        va[2].name = "satpos";  va[2].data = 20'h7FFFF; va[2].w = {4{20'h7FFFF}};
        va[2].bias = 20'h00000; va[2].exp  = {4{20'h7FFFF}};
        va[3].name = "satneg";  va[3].data = 20'h7FFFF; va[3].w = {4{20'h80000}};
        va[3].bias = 20'h00000; va[3].exp  = {4{20'h80000}};
        va[4].name = "perneur"; va[4].data = 20'h10000;
        va[4].w    = {20'h00030, 20'h00020, 20'h00010, 20'h00000};
        va[4].bias = 20'h00000;
        va[4].exp  = {20'h18000, 20'h10000, 20'h08000, 20'h00000};
        vb[0].name = "rndup";   vb[0].data = 20'h00001; vb[0].w = {4{20'h08000}};
        vb[0].bias = 20'h00000; vb[0].exp  = {4{20'h00001}};
        vb[1].name = "rnddn";   vb[1].data = 20'h00001; vb[1].w = {4{20'h07FFF}};
        vb[1].bias = 20'h00000; vb[1].exp  = {4{20'h00000}};

        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        cur_data = 20'h0; cur_bias = 20'h0; cur_w = '0;
        data_b = 20'h0; w_b = 20'h0; bias_b = 20'h0;
        repeat (3) @(negedge clk);
        chk("reset_outs_a", 72'({busy_a, done_a, crd_a, caddr_rd_a, csel_rd_a, waddr_a, bias_sel_a,
                                 cwr_a, caddr_wr_a, cdata_wr_a, csel_wr_a}), 72'd0);
        chk("reset_outs_b", 72'({busy_b, done_b, crd_b, caddr_rd_b, csel_rd_b, waddr_b, bias_sel_b,
                                 cwr_b, caddr_wr_b, cdata_wr_b, csel_wr_b}), 72'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            cur_data = va[i].data; cur_w = va[i].w; cur_bias = va[i].bias;
            run_a(va[i].name, va[i].exp, 1'b0);
        end

        for (int i = 0; i < 2; i++) begin
            data_b = vb[i].data; w_b = vb[i].w[0]; bias_b = vb[i].bias;
            run_b(vb[i].name, vb[i].exp[0]);
        end

        // Abort during neuron 2's MAC phase, then rerun with a stray start while busy.
        cur_data = va[4].data; cur_w = va[4].w; cur_bias = va[4].bias;
        wa_addr.delete();
        wa_data.delete();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n = 0;
        while (wa_addr.size() < 2 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("abort reached_n2", 72'(wa_addr.size()), 72'd2);
        repeat (50) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("abort outs", 72'({busy_a, done_a, crd_a, caddr_rd_a, csel_rd_a, waddr_a, bias_sel_a,
                               cwr_a, caddr_wr_a, cdata_wr_a, csel_wr_a}), 72'd0);
        @(negedge clk);
        rst_a = 1'b0;
        n = 0;
        repeat (2100) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) n++;
        end
        chk("abort no_done", 72'(n), 72'd0);
        chk("abort no_write", 72'(wa_addr.size()), 72'd2);
        run_a("rerun", va[4].exp, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
